// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer
// Takes one measurement command at a time, drives the instrumented adder
// through settle / ring-run / settle, samples the quiescent ring counter and
// sum, and returns the result on a valid/ready stream.
// Every output comes straight from a flop; the next values are computed in a
// single combinational block from the current state and the inputs.

module adder_measure_sequencer #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    // command stream
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_ring_bit,
    input  logic [WIN_W-1:0] cmd_window,
    // adder control
    output logic [WIDTH-1:0] a_input,
    output logic [WIDTH-1:0] b_input,
    output logic [WIDTH-1:0] a_input_ring_bit_b,
    output logic             ring_en,
    output logic             cnt_clr,
    // adder observation
    input  logic [CNT_W-1:0] ring_count,
    input  logic [WIDTH-1:0] sum_in,
    // result stream
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_err
);

    // One down-counter times LOAD, RUN and STOP, so it must hold both the
    // window length and SETTLE-1.
    localparam int SEQ_W = (WIN_W > $clog2(SETTLE) + 1) ? WIN_W : $clog2(SETTLE) + 1;
    localparam logic [SEQ_W-1:0] SETTLE_LAST = SEQ_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_STOP,
        ST_CAPTURE,
        ST_RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [WIN_W-1:0] win_q, win_d;

    logic [WIDTH-1:0] a_d, b_d, sel_d;
    logic [CNT_W-1:0] res_count_d;
    logic [WIDTH-1:0] res_sum_d;
    logic             res_err_d;
    logic             ring_en_d, cnt_clr_d, res_valid_d, cmd_ready_d;
    logic             multi_hot;

    // More than one bit set in the ring select: x & (x-1) clears the lowest set bit.
    assign multi_hot = |(cmd_ring_bit & (cmd_ring_bit - WIDTH'(1)));

    // Next-state and next-output decode for the measurement sequence.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        seq_cnt_d   = seq_cnt_q;
        win_d       = win_q;
        a_d         = a_input;
        b_d         = b_input;
        sel_d       = a_input_ring_bit_b;
        res_count_d = res_count;
        res_sum_d   = res_sum;
        res_err_d   = res_err;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (multi_hot) begin
                        // Rejected: the adder is left exactly as it was.
                        state_d     = ST_RESULT;
                        res_err_d   = 1'b1;
                        res_count_d = '0;
                        res_sum_d   = '0;
                    end else begin
                        state_d   = ST_LOAD;
                        seq_cnt_d = SETTLE_LAST;
                        win_d     = cmd_window;
                        a_d       = cmd_a;
                        b_d       = cmd_b;
                        sel_d     = ~cmd_ring_bit;
                    end
                end
            end
            ST_LOAD: begin
                if (seq_cnt_q == '0) begin
                    if (win_q == '0) begin
                        state_d   = ST_STOP;
                        seq_cnt_d = SETTLE_LAST;
                    end else begin
                        state_d   = ST_RUN;
                        seq_cnt_d = SEQ_W'(win_q) - SEQ_W'(1);
                    end
                end else begin
                    seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
            end
            ST_RUN: begin
                if (seq_cnt_q == '0) begin
                    state_d   = ST_STOP;
                    seq_cnt_d = SETTLE_LAST;
                end else begin
                    seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
            end
            ST_STOP: begin
                if (seq_cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
            end
            ST_CAPTURE: begin
                // Ring has been stopped for SETTLE cycles, so counter and sum are quiet.
                state_d     = ST_RESULT;
                res_count_d = ring_count;
                res_sum_d   = sum_in;
                res_err_d   = 1'b0;
                sel_d       = '1;
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flags follow the state being entered, so they are valid from the
        // first cycle of that state.
        ring_en_d   = (state_d == ST_RUN);
        cnt_clr_d   = (state_q == ST_IDLE) && (state_d == ST_LOAD);
        res_valid_d = (state_d == ST_RESULT);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State, sequencing counter and all registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q            <= ST_IDLE;
            seq_cnt_q          <= '0;
            win_q              <= '0;
            cmd_ready          <= 1'b1;
            a_input            <= '0;
            b_input            <= '0;
            a_input_ring_bit_b <= '1;
            ring_en            <= 1'b0;
            cnt_clr            <= 1'b0;
            res_valid          <= 1'b0;
            res_count          <= '0;
            res_sum            <= '0;
            res_err            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, independent of statement order.
            state_q            <= state_d;
            seq_cnt_q          <= seq_cnt_d;
            win_q              <= win_d;
            cmd_ready          <= cmd_ready_d;
            a_input            <= a_d;
            b_input            <= b_d;
            a_input_ring_bit_b <= sel_d;
            ring_en            <= ring_en_d;
            cnt_clr            <= cnt_clr_d;
            res_valid          <= res_valid_d;
            res_count          <= res_count_d;
            res_sum            <= res_sum_d;
            res_err            <= res_err_d;
        end
    end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Directed bench for adder_measure_sequencer. The adder is modelled as a
// plain sum plus a ring counter that adds 3 per ring_en cycle and clears on
// cnt_clr. Cycle numbering: the cycle right after the accepting edge is k+1.

module tb_adder_measure_sequencer;

    localparam int WIDTH  = 32;
    localparam int CNT_W  = 32;
    localparam int WIN_W  = 16;
    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             wb_rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [WIDTH-1:0] cmd_ring_bit = '0;
    logic [WIN_W-1:0] cmd_window = '0;
    logic [WIDTH-1:0] a_input, b_input, a_input_ring_bit_b;
    logic             ring_en, cnt_clr;
    logic [CNT_W-1:0] ring_count;
    logic [WIDTH-1:0] sum_in;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [CNT_W-1:0] res_count;
    logic [WIDTH-1:0] res_sum;
    logic             res_err;

    int total = 0;
    int bad   = 0;

    // per-measurement observations
    int lat, en_cnt, en_first, en_last, clr_cnt, clr_at, sel_bad;

    always #5 clk = ~clk;

    adder_measure_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .WIN_W (WIN_W),
        .SETTLE(SETTLE)
    ) dut (
        .wb_clk_i          (clk),
        .wb_rst_n          (wb_rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_a             (cmd_a),
        .cmd_b             (cmd_b),
        .cmd_ring_bit      (cmd_ring_bit),
        .cmd_window        (cmd_window),
        .a_input           (a_input),
        .b_input           (b_input),
        .a_input_ring_bit_b(a_input_ring_bit_b),
        .ring_en           (ring_en),
        .cnt_clr           (cnt_clr),
        .ring_count        (ring_count),
        .sum_in            (sum_in),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_count         (res_count),
        .res_sum           (res_sum),
        .res_err           (res_err)
    );

    // Adder model: combinational sum, ring counter starts at a non-zero value
    // so a missing clear is visible.
    assign sum_in = a_input + b_input;

    always @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n)    ring_count <= 32'h55;
        else if (cnt_clr) ring_count <= '0;
        else if (ring_en) ring_count <= ring_count + 32'd3;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer a command and let it be taken at the next rising edge (edge k).
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rb, input logic [15:0] win);
        cmd_a        = a;
        cmd_b        = b;
        cmd_ring_bit = rb;
        cmd_window   = win;
        cmd_valid    = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Sample each cycle after acceptance until res_valid, bounded.
    task automatic measure(input logic [31:0] sel_exp, input int sel_span);
        lat = 0; en_cnt = 0; en_first = 0; en_last = 0;
        clr_cnt = 0; clr_at = 0; sel_bad = 0;
        do begin
            @(negedge clk);
            lat++;
            if (ring_en) begin
                en_cnt++;
                if (en_first == 0) en_first = lat;
                en_last = lat;
            end
            if (cnt_clr) begin
                clr_cnt++;
                clr_at = lat;
            end
            if (lat <= sel_span && a_input_ring_bit_b !== sel_exp) sel_bad++;
        end while (!res_valid && lat < 100);
    endtask

    // Complete the result handshake with res_ready high.
    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        #2 wb_rst_n = 1'b0;
        cmd_valid    = 1'b1;
        cmd_a        = $urandom;
        cmd_b        = $urandom;
        cmd_ring_bit = $urandom;
        cmd_window   = 16'($urandom);
        res_ready    = 1'($urandom);
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_a_input", a_input, 0);
        check("rst_b_input", b_input, 0);
        check("rst_sel", a_input_ring_bit_b, 32'hFFFF_FFFF);
        check("rst_ring_en", ring_en, 0);
        check("rst_cnt_clr", cnt_clr, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_count", res_count, 0);
        check("rst_res_sum", res_sum, 0);
        check("rst_res_err", res_err, 0);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wb_rst_n  = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_res_valid", res_valid, 0);

        // ---------------- nominal: 5+7, ring bit 4, window 10 ----------------
        send(32'd5, 32'd7, 32'h10, 16'd10);
        measure(32'hFFFF_FFEF, 18);
        check("nom_latency", lat, 20);
        check("nom_en_cycles", en_cnt, 10);
        check("nom_en_first", en_first, 5);
        check("nom_en_last", en_last, 14);
        check("nom_clr_count", clr_cnt, 1);
        check("nom_clr_at", clr_at, 1);
        check("nom_sel_bad", sel_bad, 0);
        check("nom_res_count", res_count, 30);
        check("nom_res_sum", res_sum, 12);
        check("nom_res_err", res_err, 0);
        check("nom_sel_result", a_input_ring_bit_b, 32'hFFFF_FFFF);
        check("nom_ready_busy", cmd_ready, 0);
        handshake();
        check("nom_ready_after", cmd_ready, 1);
        check("nom_valid_after", res_valid, 0);
        check("nom_a_kept", a_input, 5);
        check("nom_b_kept", b_input, 7);

        // ---------------- illegal select 0x3 ----------------
        send(32'd9, 32'd9, 32'h3, 16'd7);
        measure(32'hFFFF_FFFF, 0);
        check("ill_latency", lat, 1);
        check("ill_res_err", res_err, 1);
        check("ill_res_count", res_count, 0);
        check("ill_res_sum", res_sum, 0);
        check("ill_en_cycles", en_cnt, 0);
        check("ill_clr_count", clr_cnt, 0);
        check("ill_a_kept", a_input, 5);
        check("ill_sel", a_input_ring_bit_b, 32'hFFFF_FFFF);
        handshake();
        check("ill_ready_after", cmd_ready, 1);
        check("ill_ring_en_after", ring_en, 0);

        // ---------------- zero window ----------------
        send(32'd1, 32'd2, 32'h1, 16'd0);
        measure(32'hFFFF_FFFE, 8);
        check("zw_latency", lat, 10);
        check("zw_en_cycles", en_cnt, 0);
        check("zw_clr_count", clr_cnt, 1);
        check("zw_sel_bad", sel_bad, 0);
        check("zw_res_count", res_count, 0);
        check("zw_res_sum", res_sum, 3);
        check("zw_res_err", res_err, 0);
        handshake();

        // ---------------- backpressure, sum wraps ----------------
        res_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 16'd2);
        measure(32'h7FFF_FFFF, 10);
        check("bp_latency", lat, 12);
        check("bp_en_cycles", en_cnt, 2);
        check("bp_sel_bad", sel_bad, 0);
        // a second command is offered while the result is still pending
        cmd_a        = 32'd3;
        cmd_b        = 32'd4;
        cmd_ring_bit = 32'h2;
        cmd_window   = 16'd1;
        cmd_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", res_valid, 1);
            check("bp_count_hold", res_count, 6);
            check("bp_sum_hold", res_sum, 0);
            check("bp_ready_low", cmd_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);  // handshake edge has passed
        check("bp_ready_after", cmd_ready, 1);
        check("bp_valid_after", res_valid, 0);
        check("bp_not_taken_early", a_input, 32'hFFFF_FFFF);
        @(posedge clk);  // held command is accepted here
        #1 cmd_valid = 1'b0;
        measure(32'hFFFF_FFFD, 9);
        check("bp2_latency", lat, 11);
        check("bp2_en_cycles", en_cnt, 1);
        check("bp2_res_count", res_count, 3);
        check("bp2_res_sum", res_sum, 7);
        handshake();

        // ---------------- reset during RUN ----------------
        send(32'd10, 32'd20, 32'h4, 16'd10);
        repeat (7) @(negedge clk);  // third RUN cycle
        check("rr_ring_en_before", ring_en, 1);
        #1 wb_rst_n = 1'b0;
        #1;
        check("rr_ring_en_async", ring_en, 0);
        check("rr_res_valid", res_valid, 0);
        check("rr_cmd_ready", cmd_ready, 1);
        check("rr_a_input", a_input, 0);
        check("rr_sel", a_input_ring_bit_b, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("rr_ring_en_held", ring_en, 0);
        @(negedge clk);
        wb_rst_n = 1'b1;
        @(negedge clk);
        check("rr_idle_ready", cmd_ready, 1);
        check("rr_idle_ring_en", ring_en, 0);
        send(32'd2, 32'd3, 32'h8, 16'd4);
        measure(32'hFFFF_FFF7, 12);
        check("rr2_latency", lat, 14);
        check("rr2_en_cycles", en_cnt, 4);
        check("rr2_clr_count", clr_cnt, 1);
        check("rr2_res_count", res_count, 12);
        check("rr2_res_sum", res_sum, 5);
        check("rr2_res_err", res_err, 0);
        handshake();
        check("rr2_ready_after", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
